spi_conf_master: RTL

SPI_CONF_MASTER -- requirements
Module: spi_conf_master

---
 rtl/spi_conf_master_pkg.sv | 21 ++
 rtl/spi_conf_master_timeout.sv | 30 +++
 rtl/spi_conf_master.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spi_conf_master_pkg.sv
// Shared definitions for the configuration-write master: FSM encoding,
// channel addresses and the soft-reset request bit.
package spi_conf_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SRST   = 3'd3,
    ST_RESP   = 3'd4
  } conf_state_e;

  localparam logic [1:0] CONF_ADDR_0       = 2'd0;
  localparam logic [1:0] CONF_ADDR_1       = 2'd1;
  localparam logic [1:0] CONF_ADDR_2       = 2'd2;
  localparam logic [1:0] CONF_ADDR_ILLEGAL = 2'd3;

  localparam int SOFT_RESET_BIT  = 10;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/spi_conf_master_timeout.sv
// Handshake watchdog: counts REQ cycles without a transfer and flags the
// cycle on which the TIMEOUT-th such cycle is being spent.
module spi_conf_timeout
  import spi_conf_master_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_count;

  // Saturates at the terminal value so a stalled enable cannot wrap.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == W'(TIMEOUT - 1));

endmodule

// File: rtl/spi_conf_master.sv
// Single-outstanding configuration write master: forwards one host command to
// one of three register channels, reads the channel back and reports it.
module spi_conf_master
  import spi_conf_master_pkg::*;
#(
  parameter int CONFIG_WIDTH = 32,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_addr,
  input  logic [CONFIG_WIDTH-1:0] cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [CONFIG_WIDTH-1:0] rsp_data,
  output logic                    rsp_err,
  output logic                    conf_0_valid,
  input  logic                    conf_0_ready,
  output logic [CONFIG_WIDTH-1:0] conf_0_wdata,
  input  logic [CONFIG_WIDTH-1:0] conf_0_rdata,
  output logic                    conf_1_valid,
  input  logic                    conf_1_ready,
  output logic [CONFIG_WIDTH-1:0] conf_1_wdata,
  input  logic [CONFIG_WIDTH-1:0] conf_1_rdata,
  output logic                    conf_2_valid,
  input  logic                    conf_2_ready,
  output logic [CONFIG_WIDTH-1:0] conf_2_wdata,
  input  logic [CONFIG_WIDTH-1:0] conf_2_rdata,
  input  logic                    soft_reset
);

  conf_state_e             r_state;
  logic [1:0]              r_addr;
  logic [CONFIG_WIDTH-1:0] r_data;
  logic                    r_cmd_ready;
  logic                    r_rsp_valid;
  logic [CONFIG_WIDTH-1:0] r_rsp_data;
  logic                    r_rsp_err;

  logic                    w_in_req;
  logic                    w_accept;
  logic                    w_sel_ready;
  logic                    w_xfer;
  logic                    w_expired;
  logic [CONFIG_WIDTH-1:0] w_sel_rdata;

  assign w_in_req = (r_state == ST_REQ);
  assign w_accept = cmd_valid && r_cmd_ready;
  assign w_xfer   = w_in_req && w_sel_ready;

  // Only the addressed channel's ready/rdata are looked at.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    case (r_addr)
      CONF_ADDR_0: begin
        w_sel_ready = conf_0_ready;
        w_sel_rdata = conf_0_rdata;
      end
      CONF_ADDR_1: begin
        w_sel_ready = conf_1_ready;
        w_sel_rdata = conf_1_rdata;
      end
      CONF_ADDR_2: begin
        w_sel_ready = conf_2_ready;
        w_sel_rdata = conf_2_rdata;
      end
      default: begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
      end
    endcase
  end

  spi_conf_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_accept),
    .enable  (w_in_req && !w_xfer),
    .expired (w_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr      <= cmd_addr;
            r_data      <= cmd_data;
            r_cmd_ready <= 1'b0;
            if (cmd_addr == CONF_ADDR_ILLEGAL) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state <= ST_REQ;
            end
          end
        end
        // A transfer on the expiry cycle still counts as success.
        ST_REQ: begin
          if (w_xfer) begin
            r_state <= ST_SETTLE;
          end else if (w_expired) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
          end
        end
        ST_SETTLE: begin
          r_rsp_data <= w_sel_rdata;
          r_rsp_err  <= 1'b0;
          if ((r_addr == CONF_ADDR_0) && r_data[SOFT_RESET_BIT]) begin
            r_state <= ST_SRST;
          end else begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_SRST: begin
          if (!soft_reset) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_err      = r_rsp_err;

  assign conf_0_valid = w_in_req && (r_addr == CONF_ADDR_0);
  assign conf_1_valid = w_in_req && (r_addr == CONF_ADDR_1);
  assign conf_2_valid = w_in_req && (r_addr == CONF_ADDR_2);
  assign conf_0_wdata = r_data;
  assign conf_1_wdata = r_data;
  assign conf_2_wdata = r_data;

endmodule
